cam_line_capture: RTL and testbench
===================================

// Module: cam_line_capture
// PURPOSE
//  Oversamples OV7670 camera pins (PCLK/HREF/VSYNC/D[7:0]) in the CLK100MHz domain and packs byte pairs into RGB565 words.
//  Each line goes into one of two ping-pong line FIFOs; writeBuffSelect toggles when a line is committed.
//  Sits directly upstream of the line-buffer-to-DRAM capture controller, which drains 640 words per toggle.
// PARAMETERS
//  LINE_PIXELS   640  words committed per line (fixed length seen by the DRAM writer)
//  DATA_W        16   FIFO word width (RGB565)
//  FIFO_AW       10   FIFO address width (depth 2**FIFO_AW >= LINE_PIXELS)
//  SYNC_STAGES   2    synchronizer flops on each camera input
// PORTS
//  CLK100MHz       in   1   system clock, sole clock
//  resetN          in   1   asynchronous, active-low reset
//  camPCLK         in   1   camera pixel clock (async, <=25 MHz)
//  camHREF         in   1   camera line-valid
//  camVSYNC        in   1   camera frame sync, high = vertical blanking
//  camData         in   8   camera data byte
//  inBuffRd1       in   1   read strobe, FIFO1
//  inBuffRd2       in   1   read strobe, FIFO2
//  VSYNC           out  1   synchronized camVSYNC
//  writeBuffSelect out  1   toggles per committed line; new value names the readable FIFO (0=FIFO1, 1=FIFO2)
//  dataFIFO1       out  16  FIFO1 read data
//  dataFIFO2       out  16  FIFO2 read data
//  lineCount       out  9   lines committed in current frame
//  lineOverflow    out  1   sticky: line exceeded LINE_PIXELS
//  readUnderflow   out  1   sticky: read strobe on empty FIFO
// BEHAVIOUR
//  Reset: all outputs 0 except writeBuffSelect=1; FIFOs empty; FSM IDLE; byte phase 0.
//  Sync: PCLK, HREF, VSYNC and D all pass through SYNC_STAGES flops plus one delay flop, so they stay aligned.
//   A PCLK rise is detected when the delayed value is 0 and the synced value is 1.
//   HREF and D are sampled only on that detect cycle.
//  Write target: FIFO1 when writeBuffSelect=1, FIFO2 when 0.
//   Latency from a camPCLK pin rise to the FIFO write is <= SYNC_STAGES+2 cycles.
//  Packing: first byte of a pair is word[15:8], second is word[7:0]; one FIFO write per completed pair.
//  FSM:
//   IDLE: on PCLK-edge with HREF=1, take the byte as the high byte; clear pixCnt; go to CAPTURE.
//   CAPTURE: on each PCLK-edge with HREF=1, pack the byte.
//    Write the word only while pixCnt<LINE_PIXELS; at pixCnt==LINE_PIXELS, drop further words and set lineOverflow.
//    On the first PCLK-edge with HREF=0, an unpaired byte is discarded; go to PAD.
//   PAD: write 16'h0000 once per cycle until pixCnt==LINE_PIXELS, then go to COMMIT.
//   COMMIT: toggle writeBuffSelect, lineCount+1 (saturates at 511); go to IDLE. Held exactly one cycle.
//  VSYNC: synced VSYNC=1 forces IDLE from any state; the partial line is discarded.
//   The write-target FIFO pointers are cleared; no toggle occurs.
//   lineCount clears on the VSYNC rising edge.
//   writeBuffSelect is never forced by VSYNC, so the DRAM writer sees no spurious edge.
//  FIFO read: a read strobe pops the word at rdPtr into dataFIFOx on the next cycle (1-cycle latency).
//   Data holds when there is no strobe.
//   A strobe on an empty FIFO: pointer and data unchanged; readUnderflow=1.
//  Simultaneous read and write on the same FIFO are both honored; count is unchanged.
//  A write to a full FIFO is dropped and sets lineOverflow.
//  Sticky flags clear only on reset.
// STRUCTURE
//  cam_capture_pkg: LINE_PIXELS, DATA_W, FIFO_AW, FSM state encoding (IDLE, CAPTURE, PAD, COMMIT).
//  Sub-module line_fifo (sync single-clock FIFO, wr/rd/data/empty/full/clr), instantiated twice.
//  Top contains the synchronizers, edge detect, packer, FSM and counters.
// TESTING
//  Reset: hold resetN=0 mid-line -> all outputs 0, writeBuffSelect=1, FIFOs empty after release.
//  One line, 1280 bytes 0x12,0x34 repeating -> one toggle 1->0; 640 FIFO1 reads all return 16'h1234; lineCount=1.
//  Two lines -> line2 lands in FIFO2, writeBuffSelect back to 1; draining FIFO1 during line2 is unaffected.
//  Short line, 600 pixels -> 40 words 16'h0000 padded; toggle only after the 640th word.
//  Long line, 650 pixels -> 640 words stored, lineOverflow=1.
//   A strobe on an empty FIFO -> readUnderflow=1, data held.
//  VSYNC rises at pixel 300 -> no toggle, target FIFO empty, lineCount=0; next line captured normally.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Shared constants, FSM encoding and pin bundle for the OV7670 line capture path.
package cam_capture_pkg;
  localparam int LINE_PIXELS = 640;
  localparam int DATA_W      = 16;
  localparam int FIFO_AW     = 10;
  localparam int SYNC_STAGES = 2;
  localparam int PIX_W       = $clog2(LINE_PIXELS + 1);
  localparam int LCNT_W      = 9;

  localparam logic [PIX_W-1:0] LINE_LEN = PIX_W'(LINE_PIXELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PAD     = 2'd2,
    COMMIT  = 2'd3
  } cap_state_t;

  typedef struct packed {
    logic       vsync;
    logic       href;
    logic       pclk;
    logic [7:0] data;
  } cam_pins_t;
endpackage

// File: rtl/line_fifo.sv
// Single-clock line FIFO: registered 1-cycle read data that holds between strobes.
// Writes to a full FIFO and reads from an empty one are ignored; clr_i empties it and wins over a write.
module line_fifo #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic          rd_i,
  output logic [DW-1:0] rd_dat_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] rd_dat_q;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_dat_o = rd_dat_q;

  always_ff @(posedge clk_i) begin
    if (wr_i && !full_o && !clr_i) mem[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_dat_q <= '0;
    end else begin
      if (rd_i && !empty_o) rd_dat_q <= mem[rd_ptr_q[AW-1:0]];
      if (clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_i && !full_o)  wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rd_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cam_line_capture.sv
// OV7670 pins oversampled on CLK100MHz, byte pairs packed to RGB565, one fixed-length line per ping-pong FIFO.
// Pin rise to FIFO write is SYNC_STAGES+2 cycles; the DRAM writer drains the FIFO named by writeBuffSelect.
module cam_line_capture
  import cam_capture_pkg::*;
(
  input  logic              CLK100MHz,
  input  logic              resetN,
  input  logic              camPCLK,
  input  logic              camHREF,
  input  logic              camVSYNC,
  input  logic [7:0]        camData,
  input  logic              inBuffRd1,
  input  logic              inBuffRd2,
  output logic              VSYNC,
  output logic              writeBuffSelect,
  output logic [DATA_W-1:0] dataFIFO1,
  output logic [DATA_W-1:0] dataFIFO2,
  output logic [LCNT_W-1:0] lineCount,
  output logic              lineOverflow,
  output logic              readUnderflow
);
  cam_pins_t                 cam_in, cam_s, cam_d;
  cam_pins_t [SYNC_STAGES:0] sync_q;

  cap_state_t        state_q;
  logic [PIX_W-1:0]  pix_cnt_q;
  logic [7:0]        hi_q;
  logic              phase_q;
  logic              wr_vld_q;
  logic [DATA_W-1:0] wr_dat_q;
  logic              wbs_q;
  logic [LCNT_W-1:0] line_cnt_q;
  logic              ovf_q, udf_q;

  logic pclk_rise, vsync_rise;
  logic empty1, empty2, full1, full2, tgt_full;
  logic clr1, clr2;

  assign cam_in = {camVSYNC, camHREF, camPCLK, camData};

  always_ff @(posedge CLK100MHz or negedge resetN) begin
    if (!resetN) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-1:0], cam_in};
  end

  // HREF/data are taken from the delay stage: the cycle before the PCLK edge, well inside the data eye.
  assign cam_s      = sync_q[SYNC_STAGES-1];
  assign cam_d      = sync_q[SYNC_STAGES];
  assign pclk_rise  = cam_s.pclk & ~cam_d.pclk;
  assign vsync_rise = cam_s.vsync & ~cam_d.vsync;

  assign tgt_full = wbs_q ? full1 : full2;
  assign clr1     = cam_s.vsync & wbs_q;
  assign clr2     = cam_s.vsync & ~wbs_q;

  always_ff @(posedge CLK100MHz or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      hi_q       <= '0;
      phase_q    <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_dat_q   <= '0;
      wbs_q      <= 1'b1;
      line_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_vld_q <= 1'b0;
      if (wr_vld_q && tgt_full && !cam_s.vsync) ovf_q <= 1'b1;
      if (vsync_rise) line_cnt_q <= '0;
      if (cam_s.vsync) begin
        state_q <= IDLE;
        phase_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (pclk_rise && cam_d.href) begin
            hi_q      <= cam_d.data;
            phase_q   <= 1'b1;
            pix_cnt_q <= '0;
            state_q   <= CAPTURE;
          end
          CAPTURE: if (pclk_rise) begin
            if (!cam_d.href) begin
              phase_q <= 1'b0;
              state_q <= PAD;
            end else if (!phase_q) begin
              hi_q    <= cam_d.data;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (pix_cnt_q < LINE_LEN) begin
                wr_vld_q  <= 1'b1;
                wr_dat_q  <= {hi_q, cam_d.data};
                pix_cnt_q <= pix_cnt_q + 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
          PAD: begin
            if (pix_cnt_q < LINE_LEN) begin
              wr_vld_q  <= 1'b1;
              wr_dat_q  <= '0;
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end else begin
              state_q <= COMMIT;
            end
          end
          COMMIT: begin
            wbs_q <= ~wbs_q;
            if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK100MHz or negedge resetN) begin
    if (!resetN) udf_q <= 1'b0;
    else if ((inBuffRd1 && empty1) || (inBuffRd2 && empty2)) udf_q <= 1'b1;
  end

  line_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_fifo1 (
    .clk_i    (CLK100MHz),
    .rst_ni   (resetN),
    .clr_i    (clr1),
    .wr_i     (wr_vld_q & wbs_q),
    .wr_dat_i (wr_dat_q),
    .rd_i     (inBuffRd1),
    .rd_dat_o (dataFIFO1),
    .empty_o  (empty1),
    .full_o   (full1)
  );

  line_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_fifo2 (
    .clk_i    (CLK100MHz),
    .rst_ni   (resetN),
    .clr_i    (clr2),
    .wr_i     (wr_vld_q & ~wbs_q),
    .wr_dat_i (wr_dat_q),
    .rd_i     (inBuffRd2),
    .rd_dat_o (dataFIFO2),
    .empty_o  (empty2),
    .full_o   (full2)
  );

  assign VSYNC           = cam_s.vsync;
  assign writeBuffSelect = wbs_q;
  assign lineCount       = line_cnt_q;
  assign lineOverflow    = ovf_q;
  assign readUnderflow   = udf_q;
endmodule

// File: tb/tb_cam_line_capture.sv
// Directed bench for cam_line_capture with a word scoreboard per FIFO.
`timescale 1ns/1ps
module tb_cam_line_capture;
  logic        CLK100MHz = 1'b0;
  logic        resetN    = 1'b0;
  logic        camPCLK   = 1'b0;
  logic        camHREF   = 1'b0;
  logic        camVSYNC  = 1'b0;
  logic [7:0]  camData   = 8'h00;
  logic        inBuffRd1 = 1'b0;
  logic        inBuffRd2 = 1'b0;
  logic        VSYNC, writeBuffSelect, lineOverflow, readUnderflow;
  logic [15:0] dataFIFO1, dataFIFO2;
  logic [8:0]  lineCount;

  int checks   = 0;
  int failures = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] last_w;

  cam_line_capture dut (
    .CLK100MHz       (CLK100MHz),
    .resetN          (resetN),
    .camPCLK         (camPCLK),
    .camHREF         (camHREF),
    .camVSYNC        (camVSYNC),
    .camData         (camData),
    .inBuffRd1       (inBuffRd1),
    .inBuffRd2       (inBuffRd2),
    .VSYNC           (VSYNC),
    .writeBuffSelect (writeBuffSelect),
    .dataFIFO1       (dataFIFO1),
    .dataFIFO2       (dataFIFO2),
    .lineCount       (lineCount),
    .lineOverflow    (lineOverflow),
    .readUnderflow   (readUnderflow)
  );

  always #5 CLK100MHz = ~CLK100MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK100MHz);
    #1;
  endtask

  task automatic cam_byte(input logic [7:0] b, input logic h);
    camData = b;
    camHREF = h;
    camPCLK = 1'b0;
    tick; tick;
    camPCLK = 1'b1;
    tick; tick;
  endtask

  function automatic logic [15:0] pix(input int seed, input int i);
    logic [15:0] w;
    if (seed == 0) w = 16'h1234;
    else begin
      w[15:8] = 8'(i + seed);
      w[7:0]  = 8'((i * 7) ^ seed);
    end
    return w;
  endfunction

  task automatic send_pix(input int n, input int seed, input bit to1, input bit push);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = pix(seed, i);
      cam_byte(w[15:8], 1'b1);
      cam_byte(w[7:0], 1'b1);
      if (push && i < 640) begin
        if (to1) q1.push_back(w);
        else     q2.push_back(w);
      end
    end
  endtask

  task automatic end_line(input int n, input bit to1);
    for (int i = n; i < 640; i++) begin
      if (to1) q1.push_back(16'h0000);
      else     q2.push_back(16'h0000);
    end
    cam_byte(8'h00, 1'b0);
  endtask

  task automatic wait_wbs(input string tag, input logic exp);
    int n = 0;
    while (writeBuffSelect !== exp && n < 300) begin
      tick;
      n++;
    end
    check(tag, 32'(writeBuffSelect), 32'(exp));
  endtask

  task automatic drain(input bit f1, input string tag);
    logic [15:0] exp;
    int n = f1 ? q1.size() : q2.size();
    for (int i = 0; i < n; i++) begin
      if (f1) inBuffRd1 = 1'b1;
      else    inBuffRd2 = 1'b1;
      tick;
      inBuffRd1 = 1'b0;
      inBuffRd2 = 1'b0;
      exp = f1 ? q1.pop_front() : q2.pop_front();
      last_w = exp;
      check(tag, 32'(f1 ? dataFIFO1 : dataFIFO2), 32'(exp));
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick;
    resetN = 1'b1;
    tick;

    // Partial line with distinct data, then reset mid-line: stale words must not survive.
    send_pix(100, 5, 1'b1, 1'b0);
    resetN = 1'b0;
    tick;
    check("rst_vsync", 32'(VSYNC), 32'd0);
    check("rst_wbs", 32'(writeBuffSelect), 32'd1);
    check("rst_data1", 32'(dataFIFO1), 32'd0);
    check("rst_data2", 32'(dataFIFO2), 32'd0);
    check("rst_linecnt", 32'(lineCount), 32'd0);
    check("rst_ovf", 32'(lineOverflow), 32'd0);
    check("rst_udf", 32'(readUnderflow), 32'd0);
    camHREF = 1'b0;
    camPCLK = 1'b0;
    repeat (4) tick;
    resetN = 1'b1;
    repeat (4) tick;

    // Line 1 (0x12,0x34) into FIFO1.
    send_pix(640, 0, 1'b1, 1'b1);
    end_line(640, 1'b1);
    check("l1_no_early_toggle", 32'(writeBuffSelect), 32'd1);
    wait_wbs("l1_toggle", 1'b0);
    check("l1_linecnt", 32'(lineCount), 32'd1);

    // Line 2 into FIFO2 while FIFO1 drains.
    fork
      send_pix(640, 3, 1'b0, 1'b1);
      drain(1'b1, "l1_fifo1_word");
    join
    end_line(640, 1'b0);
    wait_wbs("l2_toggle", 1'b1);
    check("l2_linecnt", 32'(lineCount), 32'd2);
    drain(1'b0, "l2_fifo2_word");

    // Short line: 600 pixels plus 40 zero pads into FIFO1.
    send_pix(600, 7, 1'b1, 1'b1);
    end_line(600, 1'b1);
    repeat (20) tick;
    check("short_no_early_toggle", 32'(writeBuffSelect), 32'd1);
    wait_wbs("short_toggle", 1'b0);
    check("short_linecnt", 32'(lineCount), 32'd3);
    drain(1'b1, "short_fifo1_word");

    // Long line: 650 pixels, only 640 kept in FIFO2.
    check("long_ovf_before", 32'(lineOverflow), 32'd0);
    send_pix(650, 9, 1'b0, 1'b1);
    end_line(640, 1'b0);
    wait_wbs("long_toggle", 1'b1);
    check("long_ovf_after", 32'(lineOverflow), 32'd1);
    check("long_linecnt", 32'(lineCount), 32'd4);
    drain(1'b0, "long_fifo2_word");

    // Read strobe on the now-empty FIFO2.
    check("udf_before", 32'(readUnderflow), 32'd0);
    inBuffRd2 = 1'b1;
    tick;
    inBuffRd2 = 1'b0;
    tick;
    check("udf_after", 32'(readUnderflow), 32'd1);
    check("udf_data_held", 32'(dataFIFO2), 32'(last_w));

    // VSYNC mid-line into FIFO1: line discarded, no toggle, count cleared.
    send_pix(300, 11, 1'b1, 1'b0);
    camVSYNC = 1'b1;
    camHREF  = 1'b0;
    repeat (6) tick;
    check("vs_out", 32'(VSYNC), 32'd1);
    check("vs_wbs", 32'(writeBuffSelect), 32'd1);
    check("vs_linecnt", 32'(lineCount), 32'd0);
    camVSYNC = 1'b0;
    repeat (6) tick;
    check("vs_out_low", 32'(VSYNC), 32'd0);
    check("vs_wbs_after", 32'(writeBuffSelect), 32'd1);

    send_pix(640, 13, 1'b1, 1'b1);
    end_line(640, 1'b1);
    wait_wbs("vs_next_toggle", 1'b0);
    check("vs_next_linecnt", 32'(lineCount), 32'd1);
    drain(1'b1, "vs_next_fifo1_word");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
